// File: rtl/dmem_arb_pkg.sv
// Shared constants and types for the data-RAM arbiter: requester indices
// and the index type used for the winner select.
package dmem_arb_pkg;

  localparam int NREQ    = 3;
  localparam int REQ_CPU = 0;
  localparam int REQ_VGA = 1;
  localparam int REQ_PS2 = 2;

  typedef logic [$clog2(NREQ)-1:0] req_idx_t;

  function automatic req_idx_t onehot_to_idx(input logic [NREQ-1:0] oh);
    req_idx_t idx;
    idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (oh[i]) idx = req_idx_t'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/dmem_arbiter_age_prio_sel.sv
// Combinational winner select: lowest-index urgent eligible requester if any,
// otherwise lowest-index eligible requester. Output is one-hot.
module age_prio_sel
  import dmem_arb_pkg::*;
#(
  parameter int N = NREQ
) (
  input  logic [N-1:0] eligible,
  input  logic [N-1:0] urgent,
  output logic [N-1:0] win,
  output logic         valid
);

  logic [N-1:0] cand;
  logic         found;

  always_comb begin
    cand  = (|(eligible & urgent)) ? (eligible & urgent) : eligible;
    win   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (cand[i] && !found) begin
        win[i] = 1'b1;
        found  = 1'b1;
      end
    end
    valid = |eligible;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data RAM arbiter: fixed priority with age-based promotion,
// registered grant/RAM command and a one-cycle read-return pipeline.
module dmem_arbiter #(
  parameter int NREQ     = 3,
  parameter int AW       = 10,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   we,
  input  logic [NREQ*AW-1:0] addr,
  input  logic [NREQ*DW-1:0] wdata,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   rvalid,
  output logic [DW-1:0]     rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [AW-1:0]     mem_addr,
  output logic [DW-1:0]     mem_wdata,
  input  logic [DW-1:0]     mem_rdata
);
  import dmem_arb_pkg::*;

  localparam int            CW      = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WAIT);

  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] rvalid_q, rvalid_d;
  logic            mem_en_q, mem_en_d;
  logic            mem_we_q, mem_we_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
  logic [CW-1:0]   wait_cnt_q [NREQ];
  logic [CW-1:0]   wait_cnt_d [NREQ];

  logic [NREQ-1:0] eligible;
  logic [NREQ-1:0] urgent;
  logic [NREQ-1:0] win;
  logic            win_valid;
  req_idx_t        win_idx;

  // The requester holding the grant this cycle is masked so its still-held req is not re-granted.
  always_comb begin
    eligible = req & ~gnt_q;
    for (int i = 0; i < NREQ; i++) begin
      urgent[i] = (wait_cnt_q[i] == MAX_CNT);
    end
  end

  age_prio_sel #(.N(NREQ)) u_sel (
    .eligible (eligible),
    .urgent   (urgent),
    .win      (win),
    .valid    (win_valid)
  );

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      wait_cnt_d[i] = wait_cnt_q[i];
      if (!req[i] || gnt_q[i]) begin
        wait_cnt_d[i] = '0;
      end else if (wait_cnt_q[i] != MAX_CNT) begin
        wait_cnt_d[i] = wait_cnt_q[i] + 1'b1;
      end
    end
  end

  // Address and write data hold their last value when the RAM is idle.
  always_comb begin
    win_idx     = onehot_to_idx(win);
    gnt_d       = win;
    mem_en_d    = win_valid;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (win_valid) begin
      mem_we_d    = we[win_idx];
      mem_addr_d  = addr[win_idx*AW +: AW];
      mem_wdata_d = wdata[win_idx*DW +: DW];
    end
    rvalid_d = (mem_en_q && !mem_we_q) ? gnt_q : '0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      gnt_q       <= '0;
      rvalid_q    <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      for (int i = 0; i < NREQ; i++) wait_cnt_q[i] <= '0;
    end else begin
      gnt_q       <= gnt_d;
      rvalid_q    <= rvalid_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      for (int i = 0; i < NREQ; i++) wait_cnt_q[i] <= wait_cnt_d[i];
    end
  end

  assign gnt       = gnt_q;
  assign rvalid    = rvalid_q;
  assign rdata     = mem_rdata;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a 1-cycle RAM model and a read-data scoreboard.
module tb_dmem_arbiter;

  localparam int NREQ     = 3;
  localparam int AW       = 10;
  localparam int DW       = 32;
  localparam int MAX_WAIT = 8;

  logic               clk = 1'b0;
  logic               reset;
  logic [NREQ-1:0]    req, we, gnt, rvalid;
  logic [NREQ*AW-1:0] addr;
  logic [NREQ*DW-1:0] wdata;
  logic [DW-1:0]      rdata, mem_wdata, mem_rdata;
  logic               mem_en, mem_we;
  logic [AW-1:0]      mem_addr;

  typedef struct {
    int          idx;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [31:0] ram    [1024];
  logic [31:0] shadow [1024];
  int          checks   = 0;
  int          failures = 0;
  bit          mon_on   = 1'b0;

  dmem_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
    .gnt       (gnt),
    .rvalid    (rvalid),
    .rdata     (rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pat(input int a);
    return 32'hA500_0000 ^ (a * 7);
  endfunction

  // Single-port RAM model with one-cycle read latency
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int i, input logic r, input logic w,
                               input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[i]           = r;
    we[i]            = w;
    addr[i*AW +: AW] = a;
    wdata[i*DW +: DW] = d;
    if (r && w) shadow[a] = d;
  endtask

  task automatic pushRead(input int i, input int a);
    exp_t e;
    e.idx  = i;
    e.data = shadow[a];
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Mid-cycle monitor: invariants and scoreboard pop on every read return
  always @(negedge clk) begin
    if (mon_on) begin
      checkOutput("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
      checkOutput("rvalid_onehot0", 32'($onehot0(rvalid)), 32'd1);
      checkOutput("mem_en_eq_gnt", 32'(mem_en), 32'(|gnt));
      checkOutput("mem_we_implies_en", 32'(mem_we & ~mem_en), 32'd0);
      if (rvalid != '0) begin
        checkOutput("rvalid_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          checkOutput("rvalid_idx", 32'(rvalid), 32'(1 << mon_e.idx));
          checkOutput("rdata", rdata, mon_e.data);
        end
      end
    end
  end

  initial begin
    int ps2_at;
    int ps2_gnts;
    int maxw;
    int wcnt [NREQ];

    for (int a = 0; a < 1024; a++) begin
      ram[a]    = pat(a);
      shadow[a] = pat(a);
    end
    reset = 1'b0;
    req   = '1;
    we    = '0;
    addr  = '0;
    wdata = '0;

    // Test 1: reset held with all requests asserted
    for (int c = 0; c < 3; c++) begin
      tick();
      mon_on = 1'b1;
      checkOutput("t1_gnt", 32'(gnt), 32'd0);
      checkOutput("t1_mem_en", 32'(mem_en), 32'd0);
      checkOutput("t1_rvalid", 32'(rvalid), 32'd0);
    end
    req   = '0;
    reset = 1'b1;
    tick();
    checkOutput("t1_idle_gnt", 32'(gnt), 32'd0);

    // Test 2: CPU write then read back
    applyStimulus(0, 1'b1, 1'b1, 10'd100, 32'd7);
    tick();
    checkOutput("t2_wr_gnt", 32'(gnt), 32'b001);
    checkOutput("t2_wr_mem_we", 32'(mem_we), 32'd1);
    checkOutput("t2_wr_addr", 32'(mem_addr), 32'd100);
    checkOutput("t2_wr_wdata", mem_wdata, 32'd7);
    applyStimulus(0, 1'b0, 1'b0, 10'd0, 32'd0);
    tick();
    checkOutput("t2_idle_mem_en", 32'(mem_en), 32'd0);
    applyStimulus(0, 1'b1, 1'b0, 10'd100, 32'd0);
    pushRead(0, 100);
    tick();
    checkOutput("t2_rd_gnt", 32'(gnt), 32'b001);
    checkOutput("t2_rd_mem_we", 32'(mem_we), 32'd0);
    applyStimulus(0, 1'b0, 1'b0, 10'd0, 32'd0);
    tick();
    checkOutput("t2_rd_rvalid", 32'(rvalid), 32'b001);
    checkOutput("t2_rd_rdata", rdata, 32'd7);

    // Test 3: simultaneous CPU and VGA reads
    applyStimulus(0, 1'b1, 1'b0, 10'd100, 32'd0);
    applyStimulus(1, 1'b1, 1'b0, 10'd200, 32'd0);
    pushRead(0, 100);
    pushRead(1, 200);
    tick();
    checkOutput("t3_gnt_cpu", 32'(gnt), 32'b001);
    applyStimulus(0, 1'b0, 1'b0, 10'd0, 32'd0);
    tick();
    checkOutput("t3_gnt_vga", 32'(gnt), 32'b010);
    checkOutput("t3_rvalid_cpu", 32'(rvalid), 32'b001);
    applyStimulus(1, 1'b0, 1'b0, 10'd0, 32'd0);
    tick();
    checkOutput("t3_rvalid_vga", 32'(rvalid), 32'b010);
    checkOutput("t3_rdata_vga", rdata, pat(200));
    checkOutput("t3_gnt_idle", 32'(gnt), 32'd0);

    // Test 4: CPU and VGA hog the RAM, PS2 must be promoted
    applyStimulus(0, 1'b1, 1'b1, 10'd300, 32'h11);
    applyStimulus(1, 1'b1, 1'b1, 10'd301, 32'h22);
    applyStimulus(2, 1'b1, 1'b1, 10'd302, 32'h33);
    ps2_at   = 0;
    ps2_gnts = 0;
    maxw     = 0;
    for (int i = 0; i < NREQ; i++) wcnt[i] = 0;
    for (int c = 1; c <= 14; c++) begin
      tick();
      for (int i = 0; i < NREQ; i++) begin
        if (gnt[i]) wcnt[i] = 0;
        else if (req[i]) wcnt[i]++;
        if (wcnt[i] > maxw) maxw = wcnt[i];
      end
      if (gnt[0]) checkOutput("t4_cpu_addr", 32'(mem_addr), 32'd300);
      if (gnt[1]) checkOutput("t4_vga_addr", 32'(mem_addr), 32'd301);
      if (gnt[2]) begin
        ps2_gnts++;
        if (ps2_at == 0) ps2_at = c;
        checkOutput("t4_ps2_addr", 32'(mem_addr), 32'd302);
        checkOutput("t4_ps2_wdata", mem_wdata, 32'h33);
        applyStimulus(2, 1'b0, 1'b0, 10'd0, 32'd0);
      end
    end
    checkOutput("t4_ps2_latency_ok", 32'(ps2_at >= 1 && ps2_at <= MAX_WAIT + 1), 32'd1);
    checkOutput("t4_ps2_single_gnt", 32'(ps2_gnts), 32'd1);
    checkOutput("t4_max_wait_ok", 32'(maxw <= MAX_WAIT + 1), 32'd1);
    applyStimulus(0, 1'b0, 1'b0, 10'd0, 32'd0);
    applyStimulus(1, 1'b0, 1'b0, 10'd0, 32'd0);
    tick();
    tick();
    checkOutput("t4_ram_302", ram[302], 32'h33);

    // Test 5: reset lands while a VGA read is in flight
    applyStimulus(1, 1'b1, 1'b0, 10'd50, 32'd0);
    tick();
    checkOutput("t5_gnt_vga", 32'(gnt), 32'b010);
    for (int i = 0; i < NREQ; i++) applyStimulus(i, 1'b1, 1'b0, 10'd50, 32'd0);
    reset = 1'b0;
    tick();
    checkOutput("t5_rvalid_rst", 32'(rvalid), 32'd0);
    checkOutput("t5_gnt_rst", 32'(gnt), 32'd0);
    checkOutput("t5_mem_en_rst", 32'(mem_en), 32'd0);
    tick();
    checkOutput("t5_gnt_rst2", 32'(gnt), 32'd0);
    for (int i = 0; i < NREQ; i++) applyStimulus(i, 1'b0, 1'b0, 10'd0, 32'd0);
    reset = 1'b1;
    tick();
    checkOutput("t5_rvalid_after", 32'(rvalid), 32'd0);
    checkOutput("t5_gnt_after", 32'(gnt), 32'd0);

    // Test 6: PS2 withdraws after two wait cycles
    applyStimulus(0, 1'b1, 1'b1, 10'd300, 32'h11);
    applyStimulus(1, 1'b1, 1'b1, 10'd301, 32'h22);
    applyStimulus(2, 1'b1, 1'b1, 10'd303, 32'h44);
    tick();
    checkOutput("t6_gnt_cpu", 32'(gnt), 32'b001);
    tick();
    checkOutput("t6_gnt_vga", 32'(gnt), 32'b010);
    checkOutput("t6_wait_cnt_2", 32'(dut.wait_cnt_q[2]), 32'd2);
    applyStimulus(2, 1'b0, 1'b0, 10'd0, 32'd0);
    tick();
    checkOutput("t6_gnt_cpu2", 32'(gnt), 32'b001);
    checkOutput("t6_wait_cnt_clr", 32'(dut.wait_cnt_q[2]), 32'd0);
    for (int c = 0; c < 4; c++) begin
      tick();
      checkOutput("t6_no_ps2_gnt", 32'(gnt[2]), 32'd0);
      checkOutput("t6_no_ps2_access", 32'(mem_en && mem_addr == 10'd303), 32'd0);
    end
    applyStimulus(0, 1'b0, 1'b0, 10'd0, 32'd0);
    applyStimulus(1, 1'b0, 1'b0, 10'd0, 32'd0);
    tick();
    tick();
    checkOutput("t6_idle_mem_en", 32'(mem_en), 32'd0);
    checkOutput("t6_ram_303", ram[303], pat(303));

    checkOutput("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
